// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Walks an active-low column strobe across the keypad, latches the first
// (lowest-row) key it finds, debounces the press and the release with the
// same counter, and reports an accepted key as a one-cycle pulse plus a
// held code. While a key is being debounced or held, the strobe is frozen
// on that key's column.
module keypad_scanner #(
    parameter int SCAN_DIV     = 24000,
    parameter int DEBOUNCE_CNT = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Increment that sticks at the counter's maximum instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] res;
        if (v == CNT_SAT) begin
            res = v;
        end else begin
            res = v + CW'(1);
        end
        return res;
    endfunction

    // Index of the lowest active-low row; only called when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
        logic [1:0] idx;
        if (!rs[0]) begin
            idx = 2'd0;
        end else if (!rs[1]) begin
            idx = 2'd1;
        end else if (!rs[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Keypad legend: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 E 0 F D.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]    sync1_q;
    logic [3:0]    rs_q;
    state_e        state_q, state_d;
    logic [1:0]    c_q, c_d;
    logic [1:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cols_q, cols_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;

    logic row_low_s;
    logic accept_s;
    logic release_done_s;

    assign row_low_s      = ~rs_q[r_q];
    assign accept_s       = (state_q == ST_DEBOUNCE) && row_low_s && (cnt_q >= DEB_LAST);
    assign release_done_s = (state_q == ST_RELEASE) && !row_low_s && (cnt_q >= DEB_LAST);

    // State register: synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 4'b1111;
            rs_q        <= 4'b1111;
            state_q     <= ST_SCAN;
            c_q         <= 2'd0;
            r_q         <= 2'd0;
            cnt_q       <= '0;
            cols_q      <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= rows;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            cols_q      <= cols_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state logic: column walk, press/release debounce and key latching.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q >= SCAN_LAST) begin
                    cnt_d = '0;
                    if (rs_q == 4'b1111) begin
                        c_d = c_q + 2'd1;
                    end else begin
                        r_d     = lowest_low_row(rs_q);
                        state_d = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_DEBOUNCE: begin
                if (!row_low_s) begin
                    // Bounce: resume scanning this same column from a fresh dwell.
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else if (accept_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_HELD: begin
                if (row_low_s) begin
                    cnt_d = '0;
                end else begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (row_low_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (release_done_s) begin
                    state_d = ST_SCAN;
                    c_d     = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_SCAN;
                c_d     = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered column strobe and key outputs.
    always_comb begin
        key_valid_d = accept_s;
        if (accept_s) begin
            key_code_d = key_map(r_q, c_q);
        end else begin
            key_code_d = key_code_q;
        end
        if (accept_s) begin
            key_held_d = 1'b1;
        end else if (release_done_s) begin
            key_held_d = 1'b0;
        end else begin
            key_held_d = key_held_q;
        end
        case (c_d)
            2'd0:    cols_d = 4'b1110;
            2'd1:    cols_d = 4'b1101;
            2'd2:    cols_d = 4'b1011;
            2'd3:    cols_d = 4'b0111;
            default: cols_d = 4'b1110;
        endcase
    end

    assign cols      = cols_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule
